vrf_read_sequencer: RTL

- Per-lane read-request generator that sits directly upstream of the lane VRF read pipe.
- Accepts one read command per instruction operand and walks groupIndex (outer loop) and offset (inner loop), issuing one request per element onto the read pipe's enqueue port.
- Limits in-flight reads to the read pipe's data-queue depth using a credit counter.
- Consumes returned data from the read pipe's dequeue port and forwards each word with its {groupIndex, offset, last} tag, in order.

---
 rtl/vrf_read_pkg.sv | 26 ++
 rtl/vrf_read_sequencer_if.sv | 45 ++++
 rtl/read_tag_fifo.sv | 55 +++++
 rtl/vrf_read_sequencer.sv | 100 ++++++++++
 4 files changed

// File: rtl/vrf_read_pkg.sv
// vrf_read_pkg: shared widths, request/tag records and sequencer states for the lane VRF read path.
package vrf_read_pkg;
    localparam int VS_W = 5;
    localparam int OFFSET_W = 4;
    localparam int GROUP_W = 4;
    localparam int SRC_W = 4;
    localparam int INST_W = 3;

    typedef struct packed {
        logic [VS_W-1:0]     vs;
        logic [OFFSET_W-1:0] offset;
        logic [GROUP_W-1:0]  groupIndex;
        logic [SRC_W-1:0]    readSource;
        logic [INST_W-1:0]   instructionIndex;
    } read_req_t;

    typedef struct packed {
        logic [GROUP_W-1:0]  groupIndex;
        logic [OFFSET_W-1:0] offset;
        logic                last;
    } read_tag_t;

    localparam int TAG_W = $bits(read_tag_t);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} seq_state_e;
endpackage

// File: rtl/vrf_read_sequencer_if.sv
// vrf_read_sequencer_if: command, read-pipe request/data and tagged response bundle.
interface vrf_read_sequencer_if #(parameter int DATA_WIDTH = 32);
    import vrf_read_pkg::*;
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [VS_W-1:0]       cmd_bits_vs;
    logic [INST_W-1:0]     cmd_bits_instructionIndex;
    logic [SRC_W-1:0]      cmd_bits_readSource;
    logic [GROUP_W-1:0]    cmd_bits_lastGroup;
    logic [OFFSET_W-1:0]   cmd_bits_lastOffset;
    logic                  req_valid;
    logic                  req_ready;
    logic [VS_W-1:0]       req_bits_vs;
    logic [OFFSET_W-1:0]   req_bits_offset;
    logic [GROUP_W-1:0]    req_bits_groupIndex;
    logic [SRC_W-1:0]      req_bits_readSource;
    logic [INST_W-1:0]     req_bits_instructionIndex;
    logic                  rd_valid;
    logic                  rd_ready;
    logic [DATA_WIDTH-1:0] rd_bits;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_bits_data;
    logic [GROUP_W-1:0]    rsp_bits_groupIndex;
    logic [OFFSET_W-1:0]   rsp_bits_offset;
    logic                  rsp_bits_last;
    logic                  done;
    logic                  error;

    modport master (
        output cmd_valid, cmd_bits_vs, cmd_bits_instructionIndex, cmd_bits_readSource,
               cmd_bits_lastGroup, cmd_bits_lastOffset, req_ready, rd_valid, rd_bits, rsp_ready,
        input  cmd_ready, req_valid, req_bits_vs, req_bits_offset, req_bits_groupIndex,
               req_bits_readSource, req_bits_instructionIndex, rd_ready, rsp_valid, rsp_bits_data,
               rsp_bits_groupIndex, rsp_bits_offset, rsp_bits_last, done, error
    );

    modport slave (
        input  cmd_valid, cmd_bits_vs, cmd_bits_instructionIndex, cmd_bits_readSource,
               cmd_bits_lastGroup, cmd_bits_lastOffset, req_ready, rd_valid, rd_bits, rsp_ready,
        output cmd_ready, req_valid, req_bits_vs, req_bits_offset, req_bits_groupIndex,
               req_bits_readSource, req_bits_instructionIndex, rd_ready, rsp_valid, rsp_bits_data,
               rsp_bits_groupIndex, rsp_bits_offset, rsp_bits_last, done, error
    );
endinterface

// File: rtl/read_tag_fifo.sv
// read_tag_fifo: small circular FIFO with simultaneous push/pop, legal even when full.
module read_tag_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 9
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic do_push, do_pop;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return p == PW'(DEPTH - 1) ? '0 : p + PW'(1);
    endfunction

    assign empty = cnt_q == '0;
    assign full = cnt_q == CW'(DEPTH);
    assign do_pop = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head = mem_q[rd_q];

    always_comb begin
        mem_d = mem_q;
        if (do_push) mem_d[wr_q] = push_data;
        wr_d = do_push ? nxt(wr_q) : wr_q;
        rd_d = do_pop ? nxt(rd_q) : rd_q;
        cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mem_q <= '{default: '0};
            wr_q <= '0;
            rd_q <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q <= wr_d;
            rd_q <= rd_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/vrf_read_sequencer.sv
// vrf_read_sequencer: walks group/offset of one operand into the VRF read pipe under credit control and tags returned data.
module vrf_read_sequencer
    import vrf_read_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4,
    parameter int DATA_WIDTH = 32
) (
    input logic clock,
    input logic reset,
    vrf_read_sequencer_if.slave bus
);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    seq_state_e state_q, state_d;
    read_req_t req_q, req_d;
    logic [GROUP_W-1:0] last_grp_q, last_grp_d;
    logic [OFFSET_W-1:0] last_off_q, last_off_d;
    logic [CW-1:0] out_q, out_d;
    logic err_q, err_d;
    read_tag_t tag_in, tag_head;
    logic tag_full, tag_empty, has_credit, req_fire, rd_fire, off_wrap, last_elem;
    logic [DATA_WIDTH-1:0] data;

    assign off_wrap = req_q.offset == last_off_q;
    assign last_elem = off_wrap && req_q.groupIndex == last_grp_q;
    assign has_credit = out_q < CW'(MAX_OUTSTANDING) && !tag_full;
    assign rd_fire = bus.rd_valid & bus.rd_ready;
    assign req_fire = bus.req_valid & bus.req_ready;
    assign tag_in = '{groupIndex: req_q.groupIndex, offset: req_q.offset, last: last_elem};

    assign bus.cmd_ready = state_q == IDLE;
    // A credit returned this very cycle may be reused, so a full pipe keeps streaming one-for-one.
    assign bus.req_valid = state_q == ISSUE && (has_credit || rd_fire);
    assign bus.req_bits_vs = req_q.vs;
    assign bus.req_bits_offset = req_q.offset;
    assign bus.req_bits_groupIndex = req_q.groupIndex;
    assign bus.req_bits_readSource = req_q.readSource;
    assign bus.req_bits_instructionIndex = req_q.instructionIndex;
    assign bus.rd_ready = bus.rsp_ready & ~tag_empty;
    assign bus.rsp_valid = bus.rd_valid & ~tag_empty;
    assign data = bus.rd_bits;
    assign bus.rsp_bits_data = data;
    assign bus.rsp_bits_groupIndex = tag_head.groupIndex;
    assign bus.rsp_bits_offset = tag_head.offset;
    assign bus.rsp_bits_last = tag_head.last;
    assign bus.done = state_q == DRAIN && out_q == '0;
    assign bus.error = err_q;

    always_comb begin
        state_d = state_q;
        req_d = req_q;
        last_grp_d = last_grp_q;
        last_off_d = last_off_q;
        out_d = out_q + CW'(req_fire) - CW'(rd_fire);
        err_d = err_q | (bus.rd_valid & tag_empty);
        if (bus.cmd_valid && bus.cmd_ready) begin
            req_d = '{vs: bus.cmd_bits_vs, offset: '0, groupIndex: '0,
                      readSource: bus.cmd_bits_readSource,
                      instructionIndex: bus.cmd_bits_instructionIndex};
            last_grp_d = bus.cmd_bits_lastGroup;
            last_off_d = bus.cmd_bits_lastOffset;
            state_d = ISSUE;
        end
        if (req_fire) begin
            req_d.offset = off_wrap ? '0 : req_q.offset + OFFSET_W'(1);
            req_d.groupIndex = off_wrap ? req_q.groupIndex + GROUP_W'(1) : req_q.groupIndex;
            state_d = last_elem ? DRAIN : ISSUE;
        end
        if (bus.done) state_d = IDLE;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            req_q <= '0;
            last_grp_q <= '0;
            last_off_q <= '0;
            out_q <= '0;
            err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q <= req_d;
            last_grp_q <= last_grp_d;
            last_off_q <= last_off_d;
            out_q <= out_d;
            err_q <= err_d;
        end
    end

    read_tag_fifo #(.DEPTH(MAX_OUTSTANDING), .WIDTH(TAG_W)) u_tag (
        .clock(clock),
        .reset(reset),
        .push(req_fire),
        .pop(rd_fire),
        .push_data(tag_in),
        .head(tag_head),
        .full(tag_full),
        .empty(tag_empty)
    );
endmodule
